// File: rtl/sc_core_oz_pkg.sv
// Shared types and funct3 decoding for the sc_core_oz load/store unit.
// Covers legality, misalignment and forced-alignment rules for RV32I loads and stores.
package sc_core_oz_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } t_lsu_state;

  typedef struct packed {
    logic        rd_en;
    logic        wr_en;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
  } m_lsu_ctrl;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Exactly one of rd_en/wr_en must be set, with a funct3 that RV32I defines for it.
  function automatic logic lsu_op_legal(input logic rd_en, input logic wr_en,
                                        input logic [2:0] f3);
    if (rd_en == wr_en) return 1'b0;
    if (rd_en) return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    return f3 inside {F3_B, F3_H, F3_W};
  endfunction

  function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_H, F3_HU: return lo[0];
      F3_W:        return lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  // Low address bits with the bits that break natural alignment cleared.
  function automatic logic [1:0] lsu_align_lo(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_H, F3_HU: return {lo[1], 1'b0};
      F3_W:        return 2'b00;
      default:     return lo;
    endcase
  endfunction

endpackage

// File: rtl/sc_core_oz_lsu_align.sv
// Combinational lane logic for the LSU: byte enables and replicated store data,
// plus shift and sign/zero extension of the returned load word.
module sc_core_oz_lsu_align
  import sc_core_oz_pkg::*;
(
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_ext
);

  logic [31:0] shifted;

  // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
  always_comb begin
    be    = 4'b0000;
    wdata = store_data;
    if (is_load) begin
      be = 4'b1111;
    end else if (is_store) begin
      case (funct3)
        F3_B: begin
          be    = 4'b0001 << addr_lo;
          wdata = {4{store_data[7:0]}};
        end
        F3_H: begin
          be    = 4'b0011 << {addr_lo[1], 1'b0};
          wdata = {2{store_data[15:0]}};
        end
        default: be = 4'b1111;
      endcase
    end
  end

  always_comb begin
    shifted  = rdata >> {addr_lo, 3'b000};
    load_ext = shifted;
    case (funct3)
      F3_B:    load_ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_ext = {24'h000000, shifted[7:0]};
      F3_H:    load_ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   load_ext = {16'h0000, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

endmodule

// File: rtl/sc_core_oz_lsu.sv
// Load/store unit for the single-cycle core: stalls the PC while a data-memory access runs.
// Build option SC_CORE_OZ_LSU_MISALIGN_TRAP_EN: misaligned ops are dropped and flagged on misalign_err.
module sc_core_oz_lsu
  import sc_core_oz_pkg::*;
#(
  parameter int RSP_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_result,
  input  logic        mem_rd_en,
  input  logic        mem_wr_en,
  input  logic [2:0]  funct3,
  input  logic [31:0] store_data,
  output logic        lsu_stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        bus_err,
  output logic        misalign_err,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic [31:0] dmem_req_addr,
  output logic        dmem_req_we,
  output logic [3:0]  dmem_req_be,
  output logic [31:0] dmem_req_wdata,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rsp_rdata
);

  localparam int CW = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT + 1) : 1;
  localparam logic [CW:0] TO_VAL = (CW + 1)'(RSP_TIMEOUT);

  t_lsu_state  state;
  m_lsu_ctrl   ctrl_q;
  logic [CW-1:0] cnt;
  logic [CW:0]   cnt_inc;
  logic          timeout_hit;
  logic          legal;
  logic          start;
  logic [31:0]   eff_addr;
  logic [31:0]   load_ext;
`ifdef SC_CORE_OZ_LSU_MISALIGN_TRAP_EN
  logic          trap;
`endif

  always_comb begin
    legal = lsu_op_legal(mem_rd_en, mem_wr_en, funct3);
`ifdef SC_CORE_OZ_LSU_MISALIGN_TRAP_EN
    trap         = legal && lsu_misaligned(funct3, alu_result[1:0]);
    start        = legal && !trap;
    eff_addr     = alu_result;
    misalign_err = !rst && (state == IDLE) && trap;
`else
    start        = legal;
    eff_addr     = {alu_result[31:2], lsu_align_lo(funct3, alu_result[1:0])};
    misalign_err = 1'b0;
`endif
    lsu_stall = ((state == IDLE) && start) || (state == REQ) || (state == WAIT);
  end

  // The same response cycle that would expire the watchdog still delivers data.
  always_comb begin
    cnt_inc     = {1'b0, cnt} + 1'b1;
    timeout_hit = (RSP_TIMEOUT != 0) && (cnt_inc == TO_VAL);
  end

  // Request fields come straight from the registered control word, so they stay stable in REQ.
  assign dmem_req_addr = {ctrl_q.addr[31:2], 2'b00};
  assign dmem_req_we   = ctrl_q.wr_en;

  sc_core_oz_lsu_align u_align (
    .is_load    (ctrl_q.rd_en),
    .is_store   (ctrl_q.wr_en),
    .funct3     (ctrl_q.funct3),
    .addr_lo    (ctrl_q.addr[1:0]),
    .store_data (ctrl_q.store_data),
    .rdata      (dmem_rsp_rdata),
    .be         (dmem_req_be),
    .wdata      (dmem_req_wdata),
    .load_ext   (load_ext)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      ctrl_q         <= '0;
      cnt            <= '0;
      dmem_req_valid <= 1'b0;
      load_data      <= '0;
      load_valid     <= 1'b0;
      bus_err        <= 1'b0;
    end else begin
      load_valid <= 1'b0;
      bus_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ctrl_q.rd_en      <= mem_rd_en;
            ctrl_q.wr_en      <= mem_wr_en;
            ctrl_q.funct3     <= funct3;
            ctrl_q.addr       <= eff_addr;
            ctrl_q.store_data <= store_data;
            dmem_req_valid    <= 1'b1;
            state             <= REQ;
          end
        end
        REQ: begin
          if (dmem_req_ready) begin
            dmem_req_valid <= 1'b0;
            cnt            <= '0;
            state          <= ctrl_q.rd_en ? WAIT : DONE;
          end
        end
        WAIT: begin
          if (cnt != '1) cnt <= cnt + 1'b1;
          if (dmem_rsp_valid) begin
            load_data  <= load_ext;
            load_valid <= 1'b1;
            state      <= DONE;
          end else if (timeout_hit) begin
            load_data  <= '0;
            load_valid <= 1'b1;
            bus_err    <= 1'b1;
            state      <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_core_oz_lsu.sv
// Directed bench for sc_core_oz_lsu: expected requests and load results are queued
// when each operation is driven and popped when the unit produces them.
module tb_sc_core_oz_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_result;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [2:0]  funct3;
  logic [31:0] store_data;
  logic        lsu_stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        bus_err;
  logic        misalign_err;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic [31:0] dmem_req_addr;
  logic        dmem_req_we;
  logic [3:0]  dmem_req_be;
  logic [31:0] dmem_req_wdata;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_rdata;

  always #5 clk = ~clk;

  sc_core_oz_lsu #(.RSP_TIMEOUT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .alu_result     (alu_result),
    .mem_rd_en      (mem_rd_en),
    .mem_wr_en      (mem_wr_en),
    .funct3         (funct3),
    .store_data     (store_data),
    .lsu_stall      (lsu_stall),
    .load_data      (load_data),
    .load_valid     (load_valid),
    .bus_err        (bus_err),
    .misalign_err   (misalign_err),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_req_addr  (dmem_req_addr),
    .dmem_req_we    (dmem_req_we),
    .dmem_req_be    (dmem_req_be),
    .dmem_req_wdata (dmem_req_wdata),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rsp_rdata (dmem_rsp_rdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } req_exp_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } ld_exp_t;

  req_exp_t req_q[$];
  ld_exp_t  ld_q[$];
  int passed = 0;
  int failed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete access starting from IDLE; rsp_lat < 0 means memory never answers.
  task automatic run_op(input string name, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sd,
                        input int ready_lat, input int rsp_lat, input logic [31:0] rsp_word,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_ld,
                        input logic exp_err, input int exp_stall);
    req_exp_t r;
    ld_exp_t  l;
    int stalls;
    int n;
    req_q.push_back('{addr: exp_addr, be: exp_be, we: wr, wdata: exp_wdata});
    if (rd) ld_q.push_back('{data: exp_ld, err: exp_err});
    mem_rd_en  = rd;
    mem_wr_en  = wr;
    funct3     = f3;
    alu_result = addr;
    store_data = sd;
    #1;
    stalls = lsu_stall ? 1 : 0;
    check({name, "_misalign_err"}, misalign_err, 1'b0);
    tick();
    n = 0;
    while (!dmem_req_valid && n < 8) begin
      stalls += lsu_stall ? 1 : 0;
      tick();
      n++;
    end
    check({name, "_req_valid"}, dmem_req_valid, 1'b1);
    r = req_q.pop_front();
    check({name, "_req_addr"}, dmem_req_addr, r.addr);
    check({name, "_req_be"}, dmem_req_be, r.be);
    check({name, "_req_we"}, dmem_req_we, r.we);
    if (r.we) check({name, "_req_wdata"}, dmem_req_wdata, r.wdata);
    for (int i = 0; i < ready_lat; i++) begin
      stalls += lsu_stall ? 1 : 0;
      check({name, "_hold_valid"}, dmem_req_valid, 1'b1);
      check({name, "_hold_addr"}, dmem_req_addr, r.addr);
      check({name, "_hold_be"}, dmem_req_be, r.be);
      tick();
    end
    dmem_req_ready = 1'b1;
    stalls += lsu_stall ? 1 : 0;
    tick();
    dmem_req_ready = 1'b0;
    check({name, "_req_dropped"}, dmem_req_valid, 1'b0);
    if (rd) begin
      n = 0;
      while (!load_valid && n < 20) begin
        stalls += lsu_stall ? 1 : 0;
        if (rsp_lat >= 0 && n == rsp_lat) begin
          dmem_rsp_valid = 1'b1;
          dmem_rsp_rdata = rsp_word;
        end
        tick();
        dmem_rsp_valid = 1'b0;
        n++;
      end
      l = ld_q.pop_front();
      check({name, "_load_valid"}, load_valid, 1'b1);
      check({name, "_load_data"}, load_data, l.data);
      check({name, "_bus_err"}, bus_err, l.err);
    end else begin
      check({name, "_no_load_valid"}, load_valid, 1'b0);
    end
    check({name, "_done_stall"}, lsu_stall, 1'b0);
    check({name, "_stall_cycles"}, stalls, exp_stall);
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    tick();
    check({name, "_load_valid_pulse"}, load_valid, 1'b0);
    check({name, "_bus_err_pulse"}, bus_err, 1'b0);
  endtask

  // A non-request op must neither stall nor raise a request.
  task automatic nop_op(input string name, input logic rd, input logic wr, input logic [2:0] f3);
    mem_rd_en  = rd;
    mem_wr_en  = wr;
    funct3     = f3;
    alu_result = 32'h0000_0800;
    #1;
    check({name, "_stall"}, lsu_stall, 1'b0);
    tick();
    check({name, "_req_valid"}, dmem_req_valid, 1'b0);
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    tick();
  endtask

  initial begin
    #50000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst            = 1'b1;
    alu_result     = '0;
    mem_rd_en      = 1'b0;
    mem_wr_en      = 1'b0;
    funct3         = 3'b000;
    store_data     = '0;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    dmem_rsp_rdata = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_req_valid", dmem_req_valid, 1'b0);
    check("rst_req_addr", dmem_req_addr, 32'h0);
    check("rst_req_be", dmem_req_be, 4'h0);
    check("rst_req_we", dmem_req_we, 1'b0);
    check("rst_req_wdata", dmem_req_wdata, 32'h0);
    check("rst_load_data", load_data, 32'h0);
    check("rst_load_valid", load_valid, 1'b0);
    check("rst_bus_err", bus_err, 1'b0);
    check("rst_misalign_err", misalign_err, 1'b0);
    check("rst_stall", lsu_stall, 1'b0);

    run_op("sw", 1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0, 32'h0,
           32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
    run_op("sb", 1'b0, 1'b1, 3'b000, 32'h0000_0203, 32'h0000_00A5, 0, 0, 32'h0,
           32'h0000_0200, 4'b1000, 32'hA5A5_A5A5, 32'h0, 1'b0, 2);
    run_op("sh", 1'b0, 1'b1, 3'b001, 32'h0000_0702, 32'h1111_BEEF, 1, 0, 32'h0,
           32'h0000_0700, 4'b1100, 32'hBEEF_BEEF, 32'h0, 1'b0, 3);
    run_op("lb", 1'b1, 1'b0, 3'b000, 32'h0000_0301, 32'h0, 0, 0, 32'h0000_8000,
           32'h0000_0300, 4'b1111, 32'h0, 32'hFFFF_FF80, 1'b0, 3);
    run_op("lbu", 1'b1, 1'b0, 3'b100, 32'h0000_0301, 32'h0, 0, 0, 32'h0000_8000,
           32'h0000_0300, 4'b1111, 32'h0, 32'h0000_0080, 1'b0, 3);
    run_op("lh", 1'b1, 1'b0, 3'b001, 32'h0000_0402, 32'h0, 3, 0, 32'h1234_5678,
           32'h0000_0400, 4'b1111, 32'h0, 32'h0000_1234, 1'b0, 6);
    run_op("lhu_neg", 1'b1, 1'b0, 3'b101, 32'h0000_0410, 32'h0, 0, 2, 32'h0000_9ABC,
           32'h0000_0410, 4'b1111, 32'h0, 32'h0000_9ABC, 1'b0, 5);
    run_op("lw", 1'b1, 1'b0, 3'b010, 32'h0000_0420, 32'h0, 0, 0, 32'h8765_4321,
           32'h0000_0420, 4'b1111, 32'h0, 32'h8765_4321, 1'b0, 3);

    // Reset while waiting for a response abandons the load; a late response is ignored.
    mem_rd_en  = 1'b1;
    funct3     = 3'b010;
    alu_result = 32'h0000_0600;
    tick();
    check("rstw_req_valid", dmem_req_valid, 1'b1);
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    check("rstw_wait_stall", lsu_stall, 1'b1);
    mem_rd_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstw_req_valid_cleared", dmem_req_valid, 1'b0);
    check("rstw_req_be_cleared", dmem_req_be, 4'h0);
    check("rstw_req_addr_cleared", dmem_req_addr, 32'h0);
    check("rstw_load_data_cleared", load_data, 32'h0);
    check("rstw_stall_cleared", lsu_stall, 1'b0);
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = 32'hFFFF_FFFF;
    tick();
    dmem_rsp_valid = 1'b0;
    check("late_rsp_load_valid", load_valid, 1'b0);
    check("late_rsp_load_data", load_data, 32'h0);
    tick();
    check("late_rsp_load_valid_2", load_valid, 1'b0);

    run_op("lw_timeout", 1'b1, 1'b0, 3'b010, 32'h0000_0900, 32'h0, 0, -1, 32'h0,
           32'h0000_0900, 4'b1111, 32'h0, 32'h0, 1'b1, 6);
    run_op("lb_after_to", 1'b1, 1'b0, 3'b000, 32'h0000_0903, 32'h0, 0, 3, 32'h7F00_0000,
           32'h0000_0900, 4'b1111, 32'h0, 32'h0000_007F, 1'b0, 6);

    nop_op("nop_both", 1'b1, 1'b1, 3'b010);
    nop_op("nop_ld_f3_011", 1'b1, 1'b0, 3'b011);
    nop_op("nop_st_f3_100", 1'b0, 1'b1, 3'b100);

`ifdef SC_CORE_OZ_LSU_MISALIGN_TRAP_EN
    mem_rd_en  = 1'b1;
    funct3     = 3'b010;
    alu_result = 32'h0000_0502;
    #1;
    check("mis_err_pulse", misalign_err, 1'b1);
    check("mis_no_stall", lsu_stall, 1'b0);
    tick();
    check("mis_no_req", dmem_req_valid, 1'b0);
    check("mis_no_load_valid", load_valid, 1'b0);
    mem_rd_en = 1'b0;
    #1;
    check("mis_err_clear", misalign_err, 1'b0);
    tick();
`else
    run_op("lw_mis", 1'b1, 1'b0, 3'b010, 32'h0000_0502, 32'h0, 0, 0, 32'hCAFE_F00D,
           32'h0000_0500, 4'b1111, 32'h0, 32'hCAFE_F00D, 1'b0, 3);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
